// File: rtl/cu_read_command_arbiter_pkg.sv
// rtl/cu_read_command_arbiter_pkg.sv - command line and buffer status types shared by the arbiter
package cu_read_command_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic [7:0]  cu_id;
        logic [1:0]  cmd_type;
        logic [31:0] address;
        logic [7:0]  tag;
    } CommandBufferLine;

    typedef struct packed {
        logic empty;
        logic alfull;
        logic full;
        logic valid;
    } BufferStatus;

endpackage

// File: rtl/cu_read_command_arbiter_if.sv
// rtl/cu_read_command_arbiter_if.sv - producer-side and buffer-side signals of the read command arbiter
interface cu_read_command_arbiter_if #(
    parameter int NUM_REQUESTORS = 4,
    parameter int REQ_BITS       = $clog2(NUM_REQUESTORS)
);
    logic                                                          enabled_in;
    cu_read_command_arbiter_pkg::CommandBufferLine [NUM_REQUESTORS-1:0] command_in;
    cu_read_command_arbiter_pkg::BufferStatus      [NUM_REQUESTORS-1:0] command_buffer_status_out;
    cu_read_command_arbiter_pkg::BufferStatus                      read_command_buffer_status;
    cu_read_command_arbiter_pkg::CommandBufferLine                 read_command_out;
    logic [REQ_BITS-1:0]                                           last_grant_out;
    logic [31:0]                                                   commands_issued_out;
    logic [NUM_REQUESTORS-1:0]                                     overflow_out;

    modport slave (
        input  enabled_in, command_in, read_command_buffer_status,
        output command_buffer_status_out, read_command_out, last_grant_out,
               commands_issued_out, overflow_out
    );

    modport master (
        output enabled_in, command_in, read_command_buffer_status,
        input  command_buffer_status_out, read_command_out, last_grant_out,
               commands_issued_out, overflow_out
    );
endinterface

// File: rtl/cu_read_command_arbiter.sv
// rtl/cu_read_command_arbiter.sv - round-robin arbiter feeding per-requestor FIFOs into the shared CU read command buffer
module cu_read_command_arbiter
    import cu_read_command_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTORS = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int REQ_BITS       = $clog2(NUM_REQUESTORS)
) (
    input  logic                      clock,
    input  logic                      rstn,
    cu_read_command_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ALFULL_C = CNT_W'(FIFO_DEPTH - 2);

    logic                      enabled;
    CommandBufferLine          mem    [NUM_REQUESTORS][FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr [NUM_REQUESTORS];
    logic [PTR_W-1:0]          rd_ptr [NUM_REQUESTORS];
    logic [CNT_W-1:0]          count      [NUM_REQUESTORS];
    logic [CNT_W-1:0]          count_next [NUM_REQUESTORS];
    logic [NUM_REQUESTORS-1:0] push, pop, drop;
    logic [NUM_REQUESTORS-1:0] stat_empty, stat_alfull, stat_full;
    logic [REQ_BITS-1:0]       rr_ptr, winner;
    logic                      grant;
    CommandBufferLine          grant_line;

    // First non-empty FIFO at or after rr_ptr, wrapping naturally in REQ_BITS.
    always_comb begin
        logic [REQ_BITS-1:0] idx;
        grant  = 1'b0;
        winner = rr_ptr;
        idx    = '0;
        if (enabled && !bus.read_command_buffer_status.alfull) begin
            for (int k = 0; k < NUM_REQUESTORS; k++) begin
                idx = rr_ptr + REQ_BITS'(k);
                if (!grant && count[idx] != '0) begin
                    grant  = 1'b1;
                    winner = idx;
                end
            end
        end
    end

    always_comb begin
        grant_line       = mem[winner][rd_ptr[winner]];
        grant_line.valid = 1'b1;
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO being popped is accepted.
    always_comb begin
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            pop[i]  = grant && (winner == REQ_BITS'(i));
            push[i] = enabled && bus.command_in[i].valid && ((count[i] != DEPTH_C) || pop[i]);
            drop[i] = enabled && bus.command_in[i].valid && (count[i] == DEPTH_C) && !pop[i];
            count_next[i] = count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            bus.command_buffer_status_out[i] = '{empty:  stat_empty[i],
                                                 alfull: stat_alfull[i],
                                                 full:   stat_full[i],
                                                 valid:  enabled};
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= bus.command_in[i];
            end
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            enabled                 <= 1'b0;
            rr_ptr                  <= '0;
            bus.read_command_out    <= '0;
            bus.last_grant_out      <= '0;
            bus.commands_issued_out <= '0;
            bus.overflow_out        <= '0;
            stat_empty              <= '1;
            stat_alfull             <= '0;
            stat_full               <= '0;
            for (int i = 0; i < NUM_REQUESTORS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            enabled <= bus.enabled_in;
            for (int i = 0; i < NUM_REQUESTORS; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                if (drop[i]) bus.overflow_out[i] <= 1'b1;
                count[i]       <= count_next[i];
                stat_empty[i]  <= (count_next[i] == '0);
                stat_full[i]   <= (count_next[i] == DEPTH_C);
                stat_alfull[i] <= (count_next[i] >= ALFULL_C);
            end
            if (grant) begin
                bus.read_command_out    <= grant_line;
                bus.last_grant_out      <= winner;
                rr_ptr                  <= winner + REQ_BITS'(1);
                bus.commands_issued_out <= bus.commands_issued_out + 32'd1;
            end else begin
                bus.read_command_out    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cu_read_command_arbiter.sv
// tb/tb_cu_read_command_arbiter.sv - scoreboard bench for cu_read_command_arbiter
module tb_cu_read_command_arbiter;
    import cu_read_command_arbiter_pkg::*;

    localparam int N = 4;
    localparam int D = 4;

    logic clock = 1'b0;
    logic rstn  = 1'b0;
    always #5 clock = ~clock;

    cu_read_command_arbiter_if #(.NUM_REQUESTORS(N)) bus ();

    cu_read_command_arbiter #(.NUM_REQUESTORS(N), .FIFO_DEPTH(D)) dut (
        .clock (clock),
        .rstn  (rstn),
        .bus   (bus)
    );

    typedef struct {
        int               req;
        CommandBufferLine line;
    } exp_t;

    typedef struct {
        bit          out_valid;
        int          last;
        int unsigned issued;
        bit [N-1:0]  ovf;
        int          rr;
        bit [N-1:0]  empty;
        bit [N-1:0]  alfull;
        bit [N-1:0]  full;
        bit          en;
    } snap_t;

    CommandBufferLine mq [N][$];
    int               m_rr;
    bit               m_en;
    bit [N-1:0]       m_ovf;
    int unsigned      m_issued;
    int               m_last;

    exp_t  exp_q  [$];
    snap_t snap_q [$];

    int  checks = 0;
    int  errors = 0;
    bit  in_reset = 1'b1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_rr = 0; m_en = 0; m_ovf = '0; m_issued = 0; m_last = 0;
        exp_q.delete();
        snap_q.delete();
    endfunction

    function automatic CommandBufferLine rand_line();
        CommandBufferLine l;
        l.valid    = 1'b1;
        l.cu_id    = 8'($urandom);
        l.cmd_type = 2'($urandom);
        l.address  = $urandom;
        l.tag      = 8'($urandom);
        return l;
    endfunction

    // Predict the upcoming edge from the queue model, then let the edge happen and publish the prediction.
    task automatic step();
        exp_t  e;
        snap_t s;
        bit    got = 1'b0;
        int    w;
        if (m_en && !bus.read_command_buffer_status.alfull) begin
            for (int k = 0; k < N; k++) begin
                w = (m_rr + k) % N;
                if (!got && mq[w].size() > 0) begin
                    got        = 1'b1;
                    e.req      = w;
                    e.line     = mq[w].pop_front();
                    e.line.valid = 1'b1;
                end
            end
        end
        if (got) begin
            m_rr   = (e.req + 1) % N;
            m_last = e.req;
            m_issued++;
        end
        for (int i = 0; i < N; i++) begin
            if (m_en && bus.command_in[i].valid) begin
                if (mq[i].size() < D) mq[i].push_back(bus.command_in[i]);
                else                  m_ovf[i] = 1'b1;
            end
        end
        m_en = bus.enabled_in;
        s.out_valid = got;
        s.last      = m_last;
        s.issued    = m_issued;
        s.ovf       = m_ovf;
        s.rr        = m_rr;
        s.en        = m_en;
        for (int i = 0; i < N; i++) begin
            s.empty[i]  = (mq[i].size() == 0);
            s.full[i]   = (mq[i].size() == D);
            s.alfull[i] = (mq[i].size() >= D - 2);
        end
        @(posedge clock);
        #1;
        if (got) exp_q.push_back(e);
        snap_q.push_back(s);
        for (int i = 0; i < N; i++) bus.command_in[i] = '0;
    endtask

    task automatic push_on(int i);
        bus.command_in[i] = rand_line();
    endtask

    task automatic idle(int n);
        for (int c = 0; c < n; c++) step();
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_out"},    64'(bus.read_command_out), 64'(0));
        chk({tag, "_last"},   64'(bus.last_grant_out), 64'(0));
        chk({tag, "_issued"}, 64'(bus.commands_issued_out), 64'(0));
        chk({tag, "_ovf"},    64'(bus.overflow_out), 64'(0));
        chk({tag, "_rr"},     64'(dut.rr_ptr), 64'(0));
        for (int i = 0; i < N; i++)
            chk({tag, "_status"}, 64'(bus.command_buffer_status_out[i]), 64'(4'b1000));
    endtask

    always @(negedge clock) begin
        snap_t s;
        exp_t  e;
        if (rstn && !in_reset) begin
            if (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                chk("out_valid", 64'(bus.read_command_out.valid), 64'(s.out_valid));
                chk("issued",    64'(bus.commands_issued_out), 64'(s.issued));
                chk("overflow",  64'(bus.overflow_out), 64'(s.ovf));
                chk("last_grant", 64'(bus.last_grant_out), 64'(s.last));
                chk("rr_ptr",    64'(dut.rr_ptr), 64'(s.rr));
                for (int i = 0; i < N; i++)
                    chk("status", 64'(bus.command_buffer_status_out[i]),
                        64'({s.empty[i], s.alfull[i], s.full[i], s.en}));
            end
            if (bus.read_command_out.valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", 64'(bus.read_command_out), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_payload", 64'(bus.read_command_out), 64'(e.line));
                    chk("cmd_winner",  64'(bus.last_grant_out), 64'(e.req));
                end
            end else begin
                chk("idle_out_zero", 64'(bus.read_command_out), 64'(0));
            end
        end
    end

    initial begin
        bus.enabled_in = 1'b0;
        bus.read_command_buffer_status = '0;
        for (int i = 0; i < N; i++) bus.command_in[i] = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("reset");
        rstn = 1'b1;
        in_reset = 1'b0;

        // single command on requestor 2
        bus.enabled_in = 1'b1;
        idle(2);
        push_on(2);
        idle(4);

        // all requestors, three commands each
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < N; i++) push_on(i);
            step();
        end
        idle(14);

        // downstream almost-full holds two commands back
        bus.read_command_buffer_status.alfull = 1'b1;
        push_on(0);
        push_on(3);
        step();
        idle(4);
        bus.read_command_buffer_status.alfull = 1'b0;
        idle(4);

        // overfill requestor 0
        bus.read_command_buffer_status.alfull = 1'b1;
        for (int p = 0; p < 5; p++) begin
            push_on(0);
            step();
        end
        idle(1);
        bus.read_command_buffer_status.alfull = 1'b0;
        idle(7);

        // full FIFO 1 with push and pop together
        bus.read_command_buffer_status.alfull = 1'b1;
        for (int p = 0; p < 4; p++) begin
            push_on(1);
            step();
        end
        bus.read_command_buffer_status.alfull = 1'b0;
        push_on(1);
        step();
        idle(7);

        // reset while six commands are queued
        bus.read_command_buffer_status.alfull = 1'b1;
        for (int p = 0; p < 2; p++) begin
            push_on(0); push_on(1); push_on(2);
            step();
        end
        idle(1);
        in_reset = 1'b1;
        rstn = 1'b0;
        #1;
        check_reset_values("midreset");
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        rstn = 1'b1;
        in_reset = 1'b0;
        bus.read_command_buffer_status.alfull = 1'b0;
        idle(6);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            bus.enabled_in = ($urandom_range(0, 9) != 0);
            bus.read_command_buffer_status.alfull = ($urandom_range(0, 9) < 3);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 9) < 4) push_on(i);
            step();
        end

        bus.enabled_in = 1'b1;
        bus.read_command_buffer_status.alfull = 1'b0;
        idle(N * D + 6);
        @(negedge clock);
        #1;
        chk("drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
